// File: rtl/fifo_sync_if.sv
// Producer/consumer handshake bundle for fifo_sync: write request, read request, data and status flags.
interface fifo_sync_if #(
  parameter int WIDTH = 8
);
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rdata;
  logic             empty;
  logic             full;

  modport master (
    output wr_en, rd_en, wdata,
    input  rdata, empty, full
  );

  modport slave (
    input  wr_en, rd_en, wdata,
    output rdata, empty, full
  );
endinterface

// File: rtl/fifo_sync.sv
// Single-clock FIFO with registered read data and count-derived full/empty flags.
// rst_n is active-high and asynchronous despite its name.
module fifo_sync #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  fifo_sync_if.slave bus
);
  localparam int              PTR_W      = $clog2(DEPTH);
  localparam logic [PTR_W:0]   FULL_COUNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE    = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("fifo_sync: DEPTH must be a power of two and at least 2");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wptr;
  logic [PTR_W-1:0] rptr;
  logic [PTR_W:0]   count;
  logic [WIDTH-1:0] rdata_q;
  logic             wr_ok;
  logic             rd_ok;

  assign bus.empty = (count == '0);
  assign bus.full  = (count == FULL_COUNT);
  assign bus.rdata = rdata_q;

  // A read in the same cycle frees a slot, so a full FIFO still accepts the write.
  assign wr_ok = bus.wr_en && (!bus.full || bus.rd_en);
  assign rd_ok = bus.rd_en && !bus.empty;

  // Storage is not reset; a same-address read sees the old word since both use NBAs.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wptr    <= '0;
      rptr    <= '0;
      count   <= '0;
      rdata_q <= '0;
    end else begin
      if (wr_ok) begin
        wptr <= wptr + PTR_ONE;
      end
      if (rd_ok) begin
        rdata_q <= mem[rptr];
        rptr    <= rptr + PTR_ONE;
      end
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: tb/tb_fifo_sync.sv
// Directed self-checking bench for fifo_sync: reset, fill/drain, streaming, full r/w, wrap and empty boundary.
module tb_fifo_sync;
  logic clk;
  logic rst;
  int   errors;
  int   checks;

  fifo_sync_if #(.WIDTH(8)) bus ();

  fifo_sync #(.WIDTH(8), .DEPTH(8)) dut (
    .clk   (clk),
    .rst_n (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past the next rising edge so outputs have settled before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    #1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL reset_empty: got %0b expected 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL reset_full: got %0b expected 0", bus.full); end
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("[TB] FAIL reset_rdata: got %0h expected 00", bus.rdata); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    tick();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL idle_empty: got %0b expected 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL idle_full: got %0b expected 0", bus.full); end
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("[TB] FAIL idle_rdata: got %0h expected 00", bus.rdata); end
    // Put data in flight, then assert reset between edges.
    bus.wr_en = 1'b1; bus.wdata = 8'h11; tick();
    bus.wdata = 8'h22; tick();
    bus.wr_en = 1'b0; bus.rd_en = 1'b1; tick();
    bus.rd_en = 1'b0;
    checks++; if (bus.rdata !== 8'h11) begin errors++; $display("[TB] FAIL pre_reset_rdata: got %0h expected 11", bus.rdata); end
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("[TB] FAIL pre_reset_empty: got %0b expected 0", bus.empty); end
    bus.wr_en = 1'b1; bus.wdata = 8'h33;
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL async_reset_empty: got %0b expected 1", bus.empty); end
    checks++; if (bus.rdata !== 8'h00) begin errors++; $display("[TB] FAIL async_reset_rdata: got %0h expected 00", bus.rdata); end
    tick();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL held_reset_empty: got %0b expected 1", bus.empty); end
    bus.wr_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL post_reset_empty: got %0b expected 1", bus.empty); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL post_reset_full: got %0b expected 0", bus.full); end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) begin
      bus.wr_en = 1'b1; bus.wdata = 8'(i); tick();
      checks++; if (bus.full !== (i == 8)) begin errors++; $display("[TB] FAIL fill_full[%0d]: got %0b expected %0b", i, bus.full, (i == 8)); end
      checks++; if (bus.empty !== 1'b0) begin errors++; $display("[TB] FAIL fill_empty[%0d]: got %0b expected 0", i, bus.empty); end
    end
    bus.wdata = 8'd9; tick();
    checks++; if (bus.full !== 1'b1) begin errors++; $display("[TB] FAIL overflow_full: got %0b expected 1", bus.full); end
    bus.wr_en = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      bus.rd_en = 1'b1; tick();
      checks++; if (bus.rdata !== 8'(i)) begin errors++; $display("[TB] FAIL drain_rdata[%0d]: got %0h expected %0h", i, bus.rdata, 8'(i)); end
      checks++; if (bus.empty !== (i == 8)) begin errors++; $display("[TB] FAIL drain_empty[%0d]: got %0b expected %0b", i, bus.empty, (i == 8)); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL drain_full[%0d]: got %0b expected 0", i, bus.full); end
    end
    tick();
    checks++; if (bus.rdata !== 8'd8) begin errors++; $display("[TB] FAIL underflow_rdata: got %0h expected 08", bus.rdata); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL underflow_empty: got %0b expected 1", bus.empty); end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_streaming();
    pulse_reset();
    bus.wr_en = 1'b1; bus.rd_en = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      bus.wdata = 8'(i); tick();
      checks++; if (bus.rdata !== 8'(i - 1)) begin errors++; $display("[TB] FAIL stream_rdata[%0d]: got %0h expected %0h", i, bus.rdata, 8'(i - 1)); end
      checks++; if (bus.empty !== 1'b0) begin errors++; $display("[TB] FAIL stream_empty[%0d]: got %0b expected 0", i, bus.empty); end
      checks++; if (bus.full !== 1'b0) begin errors++; $display("[TB] FAIL stream_full[%0d]: got %0b expected 0", i, bus.full); end
    end
    bus.wr_en = 1'b0; tick();
    checks++; if (bus.rdata !== 8'd15) begin errors++; $display("[TB] FAIL stream_tail_rdata: got %0h expected 0f", bus.rdata); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL stream_tail_empty: got %0b expected 1", bus.empty); end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_full_rw();
    logic [7:0] expect_q [8];
    for (int i = 1; i <= 8; i++) begin
      bus.wr_en = 1'b1; bus.wdata = 8'(i); tick();
    end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("[TB] FAIL fullrw_prefill: got %0b expected 1", bus.full); end
    bus.rd_en = 1'b1; bus.wdata = 8'hAA; tick();
    checks++; if (bus.rdata !== 8'd1) begin errors++; $display("[TB] FAIL fullrw_rdata: got %0h expected 01", bus.rdata); end
    checks++; if (bus.full !== 1'b1) begin errors++; $display("[TB] FAIL fullrw_full: got %0b expected 1", bus.full); end
    bus.wr_en = 1'b0;
    expect_q = '{8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'hAA};
    for (int i = 0; i < 8; i++) begin
      tick();
      checks++; if (bus.rdata !== expect_q[i]) begin errors++; $display("[TB] FAIL fullrw_drain[%0d]: got %0h expected %0h", i, bus.rdata, expect_q[i]); end
    end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL fullrw_empty: got %0b expected 1", bus.empty); end
    bus.rd_en = 1'b0;
  endtask

  task automatic test_wrap();
    for (int r = 1; r <= 3; r++) begin
      for (int k = 1; k <= 5; k++) begin
        bus.wr_en = 1'b1; bus.wdata = 8'(16 * r + k); tick();
        checks++; if (bus.empty !== 1'b0 || bus.full !== 1'b0) begin errors++; $display("[TB] FAIL wrap_wflags[%0d.%0d]: got empty=%0b full=%0b expected empty=0 full=0", r, k, bus.empty, bus.full); end
      end
      bus.wr_en = 1'b0;
      for (int k = 1; k <= 5; k++) begin
        bus.rd_en = 1'b1; tick();
        checks++; if (bus.rdata !== 8'(16 * r + k)) begin errors++; $display("[TB] FAIL wrap_rdata[%0d.%0d]: got %0h expected %0h", r, k, bus.rdata, 8'(16 * r + k)); end
        checks++; if (bus.empty !== (k == 5)) begin errors++; $display("[TB] FAIL wrap_empty[%0d.%0d]: got %0b expected %0b", r, k, bus.empty, (k == 5)); end
      end
      bus.rd_en = 1'b0;
    end
  endtask

  task automatic test_empty_boundary();
    bus.wr_en = 1'b1; bus.rd_en = 1'b1; bus.wdata = 8'h55; tick();
    checks++; if (bus.rdata !== 8'h35) begin errors++; $display("[TB] FAIL eb_rdata_hold: got %0h expected 35", bus.rdata); end
    checks++; if (bus.empty !== 1'b0) begin errors++; $display("[TB] FAIL eb_empty_after_write: got %0b expected 0", bus.empty); end
    bus.wr_en = 1'b0; tick();
    checks++; if (bus.rdata !== 8'h55) begin errors++; $display("[TB] FAIL eb_rdata: got %0h expected 55", bus.rdata); end
    checks++; if (bus.empty !== 1'b1) begin errors++; $display("[TB] FAIL eb_empty: got %0b expected 1", bus.empty); end
    bus.rd_en = 1'b0;
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    bus.wr_en = 1'b0;
    bus.rd_en = 1'b0;
    bus.wdata = 8'h00;
    test_reset();
    test_fill_drain();
    test_streaming();
    test_full_rw();
    test_wrap();
    test_empty_boundary();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/fifo_sync.md
Name: fifo_sync

Overview:
- Single-clock synchronous FIFO with registered read data and full/empty status flags.
- General-purpose rate/latency buffer between a producer and a consumer that share one clock.
- Write and read may occur in the same cycle. Overflow and underflow are blocked internally, so the block never corrupts stored data.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 8, number of storage entries; must be a power of two, at least 2.
- PTR_W, $clog2(DEPTH), pointer width (derived; not to be overridden).

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-high reset: asserted when 1, despite the name. Asserting it clears state immediately; release is sampled on clk.
- wr_en  input  1  write request; wdata is stored at the rising edge if the write is accepted.
- rd_en  input  1  read request; the oldest entry is transferred to rdata at the rising edge if the read is accepted.
- wdata  input  WIDTH  write data.
- rdata  output  WIDTH  registered read data.
- empty  output  1  FIFO holds 0 entries.
- full  output  1  FIFO holds DEPTH entries.

Behaviour:
- State:
  - Storage array mem[DEPTH].
  - Write pointer wptr and read pointer rptr, each PTR_W bits.
  - Occupancy counter count, PTR_W+1 bits, range 0..DEPTH.
- Reset (rst_n=1, asynchronous), while asserted:
  - wptr=0, rptr=0, count=0.
  - rdata=0, empty=1, full=0.
  - Memory contents need not be cleared.
  - Reset asserted mid-operation discards all stored data and any in-flight request.
- Flags are combinational from count: empty = (count==0), full = (count==DEPTH).
- Write accepted (wr_ok) = wr_en && (!full || rd_en). When full, a simultaneous read frees a slot, so the write is accepted.
- Read accepted (rd_ok) = rd_en && !empty. A read from an empty FIFO is ignored even when a write occurs in the same cycle; no bypass.
- On each rising edge:
  - wr_ok: mem[wptr] <= wdata; wptr <= wptr+1, wrapping from DEPTH-1 to 0.
  - rd_ok: rdata <= mem[rptr]; rptr <= rptr+1, wrapping.
  - count <= count + wr_ok - rd_ok. Both accepted leaves count unchanged.
- Read latency: rdata reflects the popped word after the edge that accepted rd_en, i.e. one cycle.
- rdata holds its last value when no read is accepted, including rd_en while empty.
- Write-to-read latency: a word written into an empty FIFO at edge N is readable at edge N+1.
- Rejected requests:
  - Write while full without read: wdata is dropped; pointers and count are unchanged.
  - Read while empty: no state change.
- Reading and writing the same address in one cycle (count==DEPTH with both accepted): the read returns the old contents, then the new word is stored.
- Data order is strictly first-in, first-out across pointer wrap-around.

Test Plan:
- Reset: assert rst_n=1 at any point -> empty=1, full=0, rdata=0 immediately. After release with no requests, the outputs are unchanged.
- Fill and drain: write 1..8 with rd_en=0 -> full=1 after the 8th edge. A 9th write of 9 is dropped. Then read 8 times with wr_en=0 -> rdata sequence 1..8, empty=1 after the 8th read. A further read leaves rdata=8.
- Streaming from empty: wr_en=rd_en=1 held for 15 cycles with wdata 1,2,...,15 changing each cycle:
  - First edge: stores 1, read ignored, rdata=0, empty goes 0.
  - Each later edge: rdata = previous cycle's wdata (1,2,...,14); count stays 1; full never asserts.
- Full with simultaneous read/write: fill with 1..8, then one cycle wr_en=rd_en=1 with wdata=0xAA -> rdata=1, full stays 1. Draining yields 2..8 then 0xAA.
- Wrap-around: repeated partial fill/drain (write 5, read 5, three rounds with distinct values) -> every value is returned in order and the flags are correct at each step.
- Empty boundary: read on an empty FIFO while writing 0x55 -> rdata unchanged that cycle. The next read returns 0x55, then empty=1.
